// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch initiator for a 32x1024 instruction ROM. A 10-bit word PC drives
//   the ROM; every fetch takes two cycles (address setup, then a read strobe
//   cycle). Fetched words are queued with their PC in a small circular FIFO
//   and handed to decode over a valid/ready handshake. A redirect flushes
//   the FIFO, abandons any in-flight fetch and restarts at a new PC.
//
// Parameters
//   RESET_PC  PC loaded on reset
//   DEPTH     prefetch FIFO entries (2..4)
//
// Ports
//   clk             sole clock, rising edge
//   rst_n           synchronous active-low reset
//   fetch_en        allows new ROM reads to launch
//   redirect_valid  one-cycle pulse: restart fetch at redirect_pc
//   redirect_pc     redirect target word address
//   rom_addr        ROM word address (stable through SETUP and READ)
//   rom_read_en     ROM read strobe (high during READ only)
//   rom_cs          ROM chip select (high during SETUP and READ)
//   rom_instr       ROM data, valid while rom_read_en and rom_cs are high
//   out_valid       FIFO head is presented
//   out_instr       instruction word at the FIFO head
//   out_pc          word address of out_instr
//   out_ready       decode accepts the head
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [9:0] RESET_PC = 10'd0,
  parameter int         DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [9:0]  redirect_pc,
  output logic [9:0]  rom_addr,
  output logic        rom_read_en,
  output logic        rom_cs,
  input  logic [31:0] rom_instr,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [9:0]  out_pc,
  input  logic        out_ready
);

  localparam int PW = (DEPTH > 2) ? 2 : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, SETUP, READ} state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [9:0]  pc;
  } entry_t;

  state_e          state_q, state_d;
  logic [9:0]      pc_q, pc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  entry_t          mem_q [DEPTH];

  logic            pop;
  logic            push;
  logic [CW-1:0]   cnt_after_pop;
  logic [CW-1:0]   cnt_after_push;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    push           = 1'b0;
    pop            = out_valid && out_ready;
    cnt_after_pop  = cnt_q - CW'(pop);
    cnt_after_push = cnt_after_pop + 1'b1;

    unique case (state_q)
      // Launch only when a slot is guaranteed: the count can only drop
      // between launch and the push at the end of READ.
      IDLE:  if (fetch_en && (cnt_after_pop < DEPTH_C)) state_d = SETUP;
      SETUP: state_d = READ;
      READ: begin
        push    = 1'b1;
        pc_d    = pc_q + 10'd1;
        state_d = (fetch_en && (cnt_after_push < DEPTH_C)) ? SETUP : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
    if (push) wr_ptr_d = next_ptr(wr_ptr_q);
    cnt_d = cnt_after_pop + CW'(push);

    // A redirect abandons the in-flight fetch and flushes everything; a pop
    // in the same cycle was already accepted by decode.
    if (redirect_valid) begin
      state_d  = IDLE;
      pc_d     = redirect_pc;
      cnt_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      push     = 1'b0;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // NOTE: the FIFO storage is deliberately not reset; the count gates what is
  // visible, and the head outputs are forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wr_ptr_q] <= '{instr: rom_instr, pc: pc_q};
  end

  assign rom_addr    = pc_q;
  assign rom_cs      = (state_q != IDLE);
  assign rom_read_en = (state_q == READ);

  assign out_valid   = (cnt_q != '0);
  assign out_instr   = out_valid ? mem_q[rd_ptr_q].instr : 32'h0;
  assign out_pc      = out_valid ? mem_q[rd_ptr_q].pc    : 10'h0;

endmodule
